// File: rtl/ws2812b_frame_out.sv
// ws2812b_frame_out
//   Serialises LED words onto STRIPECOUNT parallel WS2812B stripes. One word
//   carries one BITS_PER_LED field per stripe. Words pass through a one-word
//   holding buffer. A frame is LEDS_PER_FRAME words sent back-to-back,
//   followed by a CYCLES_RET low latch period.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   word_valid     word_data holds a valid LED word
//   word_data      stripe i field at [i*BITS_PER_LED +: BITS_PER_LED]
//   word_ready     holding buffer empty, so a word can be accepted
//   stripe_enable  per-stripe enable, sampled at frame start
//   msb_first      1: MSB of each field first, 0: LSB first; sampled at frame start
//   ws2812b_data   registered serial data, one bit per stripe
//   busy           high whenever not IDLE
//   frame_done     one-cycle pulse on the last latch cycle of a complete frame
//   underrun       one-cycle pulse when a frame is aborted for lack of data
module ws2812b_frame_out #(
  parameter int STRIPECOUNT    = 2,
  parameter int BITS_PER_LED   = 24,
  parameter int LEDS_PER_FRAME = 8,
  parameter int CYCLES_T0H     = 3,
  parameter int CYCLES_T1H     = 6,
  parameter int CYCLES_BIT     = 11,
  parameter int CYCLES_RET     = 450
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                word_valid,
  input  logic [STRIPECOUNT*BITS_PER_LED-1:0] word_data,
  output logic                                word_ready,
  input  logic [STRIPECOUNT-1:0]              stripe_enable,
  input  logic                                msb_first,
  output logic [STRIPECOUNT-1:0]              ws2812b_data,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                underrun
);

  localparam int CMAX = (CYCLES_BIT > CYCLES_RET) ? CYCLES_BIT : CYCLES_RET;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BITS_PER_LED);
  localparam int LW   = $clog2(LEDS_PER_FRAME + 1);
  localparam int WW   = STRIPECOUNT * BITS_PER_LED;

  localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_BIT - 1);
  localparam logic [CW-1:0] RET_LAST = CW'(CYCLES_RET - 1);
  localparam logic [CW-1:0] T0       = CW'(CYCLES_T0H);
  localparam logic [CW-1:0] T1       = CW'(CYCLES_T1H);
  localparam logic [BW-1:0] IDX_LAST = BW'(BITS_PER_LED - 1);
  localparam logic [LW-1:0] LED_LAST = LW'(LEDS_PER_FRAME - 1);

  if ((BITS_PER_LED != 24 && BITS_PER_LED != 32) ||
      !(CYCLES_T0H > 0 && CYCLES_T0H < CYCLES_T1H && CYCLES_T1H < CYCLES_BIT))
  begin : g_param_err
    $error("ws2812b_frame_out: illegal BITS_PER_LED or bit timing parameters");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_LATCH} state_t;

  state_t                 state;
  logic                   buf_full;
  logic [WW-1:0]          buf_data;
  logic [WW-1:0]          sr;
  logic [STRIPECOUNT-1:0] en_q;
  logic                   msb_q;
  logic                   aborted;
  logic [CW-1:0]          cyc;
  logic [BW-1:0]          bit_idx;
  logic [LW-1:0]          led_cnt;

  logic [CW-1:0]           cyc_nx;
  logic [BW-1:0]           bit_sel;
  logic [BITS_PER_LED-1:0] field;
  logic [STRIPECOUNT-1:0]  hi_mask;
  logic bit_end, led_end, frame_end, accept, consume, buf_full_nx;

  // The LED word stays static in sr; the current bit is picked by index so
  // both bit orders share one datapath.
  always_comb begin
    cyc_nx  = cyc + CW'(1);
    bit_sel = msb_q ? (IDX_LAST - bit_idx) : bit_idx;
    field   = '0;
    hi_mask = '0;
    for (int unsigned i = 0; i < STRIPECOUNT; i++) begin
      field      = sr[i*BITS_PER_LED +: BITS_PER_LED];
      hi_mask[i] = field[bit_sel] ? (cyc_nx < T1) : (cyc_nx < T0);
    end
  end

  always_comb begin
    bit_end     = (state == ST_BIT) && (cyc == BIT_LAST);
    led_end     = bit_end && (bit_idx == IDX_LAST);
    frame_end   = led_end && (led_cnt == LED_LAST);
    consume     = ((state == ST_IDLE) && buf_full) || (led_end && !frame_end && buf_full);
    accept      = word_valid && word_ready;
    buf_full_nx = accept || (buf_full && !consume);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      sr           <= '0;
      en_q         <= '0;
      msb_q        <= 1'b0;
      aborted      <= 1'b0;
      cyc          <= '0;
      bit_idx      <= '0;
      led_cnt      <= '0;
      ws2812b_data <= '0;
      word_ready   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      buf_full   <= buf_full_nx;
      word_ready <= !buf_full_nx;
      if (accept) buf_data <= word_data;

      case (state)
        ST_IDLE: begin
          if (buf_full) begin
            sr           <= buf_data;
            en_q         <= stripe_enable;
            msb_q        <= msb_first;
            aborted      <= 1'b0;
            cyc          <= '0;
            bit_idx      <= '0;
            led_cnt      <= '0;
            state        <= ST_BIT;
            busy         <= 1'b1;
            ws2812b_data <= stripe_enable;
          end
        end

        ST_BIT: begin
          if (!bit_end) begin
            cyc          <= cyc_nx;
            ws2812b_data <= en_q & hi_mask;
          end else begin
            cyc <= '0;
            if (!led_end) begin
              bit_idx      <= bit_idx + BW'(1);
              ws2812b_data <= en_q;
            end else if (frame_end) begin
              state        <= ST_LATCH;
              ws2812b_data <= '0;
              frame_done   <= (RET_LAST == '0);
            end else if (buf_full) begin
              sr           <= buf_data;
              bit_idx      <= '0;
              led_cnt      <= led_cnt + LW'(1);
              ws2812b_data <= en_q;
            end else begin
              state        <= ST_LATCH;
              ws2812b_data <= '0;
              underrun     <= 1'b1;
              aborted      <= 1'b1;
            end
          end
        end

        ST_LATCH: begin
          ws2812b_data <= '0;
          if (cyc == RET_LAST) begin
            cyc   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cyc <= cyc_nx;
            if (cyc_nx == RET_LAST && !aborted) frame_done <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ws2812b_frame_out.md
WS2812B_FRAME_OUT -- requirements
Module: ws2812b_frame_out

Interface
REQ-001 SHALL have parameter STRIPECOUNT, default 2, number of parallel stripes driven.
REQ-002 SHALL have parameter BITS_PER_LED, default 24, bits per LED; only 24 (GRB) or 32 (GRBW) are legal.
REQ-003 SHALL have parameter LEDS_PER_FRAME, default 8, LED words per frame.
REQ-004 SHALL have parameter CYCLES_T0H, default 3, high cycles for a 0 bit.
REQ-005 SHALL have parameter CYCLES_T1H, default 6, high cycles for a 1 bit.
REQ-006 SHALL have parameter CYCLES_BIT, default 11, total cycles per bit.
REQ-007 SHALL have parameter CYCLES_RET, default 450, low latch cycles after a frame.
REQ-008 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-010 SHALL have port word_valid  input  1  word_data holds a valid LED word.
REQ-011 SHALL have port word_data  input  STRIPECOUNT*BITS_PER_LED  word; stripe i uses bits [i*BITS_PER_LED +: BITS_PER_LED].
REQ-012 SHALL have port word_ready  output  1  block can accept a word this cycle.
REQ-013 SHALL have port stripe_enable  input  STRIPECOUNT  per-stripe enable, sampled at frame start.
REQ-014 SHALL have port msb_first  input  1  1 = MSB of each stripe field sent first, 0 = LSB first; sampled at frame start.
REQ-015 SHALL have port ws2812b_data  output  STRIPECOUNT  registered serial LED data.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse at end of latch after a complete frame.
REQ-018 SHALL have port underrun  output  1  one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-019 SHALL have states IDLE, BIT, LATCH, plus a one-word holding buffer between the handshake and the shift register.
REQ-020 SHALL accept a word on a rising edge where word_valid && word_ready; word_ready = holding buffer empty, in every state.
REQ-021 In IDLE with the buffer full, SHALL on the next edge move the buffer into the shift register, sample stripe_enable and msb_first, clear the LED count, enter BIT and drive the first bit's high phase; first ws2812b_data high occurs one cycle after the accept edge.
REQ-022 Each bit SHALL last exactly CYCLES_BIT cycles: enabled stripe i high for CYCLES_T1H cycles if its bit is 1, CYCLES_T0H if 0, then low for the remainder.
REQ-023 Disabled stripes SHALL drive 0 for the whole frame.
REQ-024 After bit BITS_PER_LED-1 of an LED, the next LED's first bit SHALL start with no gap, using the buffer word, which frees the buffer the same edge.
REQ-025 If the buffer is empty when a next LED is due (count < LEDS_PER_FRAME), the block SHALL pulse underrun, drive all outputs low, and enter LATCH; no frame_done is issued for that frame.
REQ-026 After LED LEDS_PER_FRAME-1 completes, SHALL enter LATCH with all outputs low for CYCLES_RET cycles, pulse frame_done on the last LATCH cycle, then return to IDLE.
REQ-027 A word accepted during BIT beyond the frame's last LED or during LATCH SHALL stay buffered and start the next frame from IDLE.
REQ-028 Counters SHALL be $clog2(max(CYCLES_BIT,CYCLES_RET)+1) bits wide; bit index $clog2(BITS_PER_LED) bits; LED count $clog2(LEDS_PER_FRAME+1) bits.
REQ-029 Illegal parameters (BITS_PER_LED not 24/32, or not 0<CYCLES_T0H<CYCLES_T1H<CYCLES_BIT) SHALL raise an elaboration/simulation $error.

Reset
REQ-030 While resetn is low at an edge: state IDLE, buffer empty, ws2812b_data=0, word_ready=0, busy=0, frame_done=0, underrun=0; word_ready=1 from the first edge after release.
REQ-031 Reset mid-frame SHALL abort at the next edge with no frame_done/underrun pulse and no LATCH period.

Verification
REQ-032 Defaults, LEDS_PER_FRAME=1, word stripe0=0xAA0000, stripe1=0x000001, msb_first=1, enable=2'b11 -> stripe0 first bit 6 high/5 low, stripe1 first 23 bits 3 high/8 low, last bit 6/5; 450 low; frame_done once.
REQ-033 msb_first=0 with stripe0=0x000001 -> stripe0 first bit is a 1 (6 high), remaining 23 bits 0.
REQ-034 LEDS_PER_FRAME=3, source supplies 3 words back-to-back -> 72 contiguous bit periods of 11 cycles, no gaps, single frame_done.
REQ-035 LEDS_PER_FRAME=3, second word withheld -> underrun pulse after LED 0's 24 bits, outputs low for 450 cycles, no frame_done.
REQ-036 enable=2'b01 -> ws2812b_data[1] constantly 0 while stripe 0 transmits normally.
REQ-037 resetn low for 1 cycle at bit 10 -> outputs 0, busy 0 next edge; a new word then restarts a full frame from bit 0.
